// File: rtl/timer_irq_pkg.sv
// Shared definitions for the timer interrupt collector: FSM state encoding,
// parameter range limits and the saturation limit helper for the miss counter.
package timer_irq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } irq_state_t;

    localparam int NUM_SRC_MIN = 2;
    localparam int NUM_SRC_MAX = 16;
    localparam int CNT_W_MIN   = 1;
    localparam int CNT_W_MAX   = 31;

    // Largest value a CNT_W-bit saturating counter may hold.
    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/timer_irq_arb.sv
// Combinational winner selection over the unmasked pending sources.
// Default: fixed priority, lowest index wins.
// With TIMER_IRQ_ROUND_ROBIN_EN defined, the search starts at 'start' and wraps.
module timer_irq_arb
    import timer_irq_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    localparam int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] cand,
`ifdef TIMER_IRQ_ROUND_ROBIN_EN
    input  logic [ID_W-1:0]    start,
`endif
    output logic [ID_W-1:0]    winner,
    output logic               valid
);

`ifdef TIMER_IRQ_ROUND_ROBIN_EN
    // Scan from the start pointer upward, wrapping at NUM_SRC; first hit wins.
    always_comb begin
        int             idx;
        logic [ID_W-1:0] idx_w;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        idx_w  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(start) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            idx_w = ID_W'(idx);
            if (!valid && cand[idx_w]) begin
                valid  = 1'b1;
                winner = idx_w;
            end
        end
    end
`else
    // Scan downward so the lowest set index is the last (and final) assignment.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                valid  = 1'b1;
                winner = ID_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt collector: edge-detects each timer interrupt into a pending
// register, masks and arbitrates among pending sources, and presents the winner
// through a req/ack handshake with a stable id. Edges arriving while their
// source is already pending are counted in a saturating miss counter.
// Optional macro TIMER_IRQ_ROUND_ROBIN_EN selects round-robin arbitration.
module timer_irq_ctrl
    import timer_irq_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    parameter  int CNT_W   = 8,
    localparam int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [NUM_SRC-1:0] mask,
    input  logic [NUM_SRC-1:0] clear,
    input  logic               irq_ack,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [CNT_W-1:0]   miss_cnt
);

    localparam int unsigned CNT_MAX = cnt_max(CNT_W);

    irq_state_t         state;
    irq_state_t         state_nxt;
    logic [NUM_SRC-1:0] irq_d;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] ack_vec;
    logic [NUM_SRC-1:0] pend_clr;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] miss_vec;
    logic [NUM_SRC-1:0] cand;
    logic [ID_W-1:0]    win_id;
    logic               win_vld;
    logic               ack_fire;
    logic               load_id;
    logic               req_live;

    function automatic int unsigned popcount(input logic [NUM_SRC-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                  input int unsigned     inc);
        int unsigned sum;
        sum = 32'(cnt) + inc;
        if (sum > CNT_MAX) begin
            sum = CNT_MAX;
        end
        return CNT_W'(sum);
    endfunction

    // Rising-edge detect, pending update (set beats clear/ack) and miss detection.
    always_comb begin
        rise        = irq_in & ~irq_d;
        ack_vec     = '0;
        if (ack_fire) begin
            ack_vec[irq_id] = 1'b1;
        end
        pend_clr    = clear | ack_vec;
        pending_nxt = (pending & ~pend_clr) | rise;
        miss_vec    = rise & pending & ~pend_clr;
        cand        = pending & mask;
        req_live    = pending[irq_id] & mask[irq_id];
    end

`ifdef TIMER_IRQ_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr;

    // Pointer moves to the slot after the acknowledged source; aborts leave it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (ack_fire) begin
            rr_ptr <= (irq_id == ID_W'(NUM_SRC - 1)) ? '0 : irq_id + 1'b1;
        end
    end

    timer_irq_arb #(.NUM_SRC(NUM_SRC)) u_arb (
        .cand   (cand),
        .start  (rr_ptr),
        .winner (win_id),
        .valid  (win_vld)
    );
`else
    timer_irq_arb #(.NUM_SRC(NUM_SRC)) u_arb (
        .cand   (cand),
        .winner (win_id),
        .valid  (win_vld)
    );
`endif

    // Edge history, pending bits and the saturating miss counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_d    <= '0;
            pending  <= '0;
            miss_cnt <= '0;
        end else begin
            irq_d    <= irq_in;
            pending  <= pending_nxt;
            miss_cnt <= sat_add(miss_cnt, popcount(miss_vec));
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: ack beats abort in REQ; GAP always lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_nxt = GAP;
                end else if (!req_live) begin
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode: request is a pure function of the registered state.
    always_comb begin
        irq_req  = (state == REQ);
        ack_fire = (state == REQ) && irq_ack;
        load_id  = (state == IDLE) && win_vld;
    end

    // Source id is captured on grant and held through REQ and afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_id <= '0;
        end else if (load_id) begin
            irq_id <= win_id;
        end
    end

endmodule
